// File: rtl/opb_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opb_reg_bank_pkg
// Brief    : Shared types and helpers for the OPB register bank: FSM states,
//            word-region decode and OPB byte-enable to user byte-mask mapping.
// Revision : 1.0 - initial release
// ============================================================================
package opb_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_CTRL   = 2'd0,
        RGN_STAT   = 2'd1,
        RGN_COMMIT = 2'd2,
        RGN_NONE   = 2'd3
    } region_t;

    localparam int WORD_SHIFT = 2;

    function automatic region_t decode_region(
        input logic [31:0] k,
        input int unsigned n_out,
        input int unsigned n_in,
        input logic        shadow_en
    );
        region_t r;
        if (k < n_out)
            r = RGN_CTRL;
        else if (k < n_out + n_in)
            r = RGN_STAT;
        else if (shadow_en && (k == n_out + n_in))
            r = RGN_COMMIT;
        else
            r = RGN_NONE;
        return r;
    endfunction

    // OPB is big-endian: BE[0] guards the most significant user byte.
    function automatic logic [31:0] be_to_mask(input logic [0:3] be);
        return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/opb_byte_reg.sv
`default_nettype none
// ============================================================================
// Module   : opb_byte_reg
// Brief    : 32-bit register with byte-masked write and parametrised reset.
// Revision : 1.0 - initial release
// ============================================================================
module opb_byte_reg #(
    parameter logic [31:0] INIT = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] mask,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= INIT;
        else if (we)
            q <= (q & ~mask) | (wdata & mask);
    end

endmodule
`default_nettype wire

// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_bank_ppc2simulink
// Brief    : OPB slave exposing N_OUT control and N_IN status registers with
//            per-register update strobes. Define OPB_REG_BANK_SHADOW_EN for
//            shadowed control registers with an atomic COMMIT word.
// Revision : 1.0 - initial release
// ============================================================================
module opb_register_bank_ppc2simulink
    import opb_reg_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_07FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_OUT        = 4,
    parameter int          N_IN         = 2,
    parameter logic [31:0] C_INIT       = 32'h0
) (
    input  logic                                OPB_Clk,
    input  logic                                OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]             OPB_ABus,
    input  logic [0:3]                          OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]             OPB_DBus,
    input  logic                                OPB_RNW,
    input  logic                                OPB_select,
    input  logic                                OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]             Sl_DBus,
    output logic                                Sl_errAck,
    output logic                                Sl_retry,
    output logic                                Sl_toutSup,
    output logic                                Sl_xferAck,
    output logic [32*N_OUT-1:0]                 user_data_out,
    output logic [N_OUT-1:0]                    user_wr_strobe,
    input  logic [32*((N_IN > 0) ? N_IN : 1)-1:0] user_data_in
);

`ifdef OPB_REG_BANK_SHADOW_EN
    localparam logic c_shadow_en = 1'b1;
`else
    localparam logic c_shadow_en = 1'b0;
`endif

    state_t                  r_state;
    logic [31:0]             r_k;
    region_t                 r_region;
    logic                    r_rnw;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mask;
    logic [31:0]             r_dbus;
    logic                    r_xfer_ack;
    logic [N_OUT-1:0]        r_strobe;

    logic [C_OPB_AWIDTH-1:0] w_addr;
    logic [C_OPB_AWIDTH-1:0] w_offset;
    logic [31:0]             w_k;
    logic                    w_hit;
    region_t                 w_region;
    logic [31:0]             w_rdata;
    logic [32*N_OUT-1:0]     w_ctrl_view;
    logic                    w_wr_cycle;
    logic [N_OUT-1:0]        w_ctrl_we;
    logic                    unused_inputs;

    assign unused_inputs = OPB_seqAddr;

    assign w_addr   = OPB_ABus;
    assign w_hit    = (w_addr >= C_BASEADDR[C_OPB_AWIDTH-1:0]) &&
                      (w_addr <= C_HIGHADDR[C_OPB_AWIDTH-1:0]);
    assign w_offset = w_addr - C_BASEADDR[C_OPB_AWIDTH-1:0];
    assign w_k      = 32'(w_offset >> WORD_SHIFT);
    assign w_region = decode_region(w_k, N_OUT, N_IN, c_shadow_en);

    // Read data is resolved in the decode cycle so status inputs are sampled there.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (w_region == RGN_CTRL && w_k == 32'(i))
                w_rdata = w_ctrl_view[32*i +: 32];
        end
        for (int j = 0; j < N_IN; j++) begin
            if (w_region == RGN_STAT && w_k == 32'(N_OUT + j))
                w_rdata = user_data_in[32*j +: 32];
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            r_state    <= IDLE;
            r_xfer_ack <= 1'b0;
            r_dbus     <= '0;
            r_k        <= '0;
            r_region   <= RGN_NONE;
            r_rnw      <= 1'b1;
            r_wdata    <= '0;
            r_mask     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (OPB_select && w_hit) begin
                        r_state    <= ACK;
                        r_xfer_ack <= 1'b1;
                        r_dbus     <= OPB_RNW ? w_rdata : 32'h0;
                        r_k        <= w_k;
                        r_region   <= w_region;
                        r_rnw      <= OPB_RNW;
                        r_wdata    <= OPB_DBus;
                        r_mask     <= be_to_mask(OPB_BE);
                    end
                end
                ACK: begin
                    r_state    <= WAIT;
                    r_xfer_ack <= 1'b0;
                    r_dbus     <= '0;
                end
                WAIT: begin
                    if (!OPB_select)
                        r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_xfer_ack <= 1'b0;
                    r_dbus     <= '0;
                end
            endcase
        end
    end

    // Writes retire on the edge that ends the ACK cycle.
    assign w_wr_cycle = (r_state == ACK) && !r_rnw;

    always_comb begin
        w_ctrl_we = '0;
        for (int i = 0; i < N_OUT; i++)
            w_ctrl_we[i] = w_wr_cycle && (r_region == RGN_CTRL) && (r_k == 32'(i));
    end

`ifdef OPB_REG_BANK_SHADOW_EN
    logic             w_commit;
    logic [N_OUT-1:0] r_dirty;

    assign w_commit = w_wr_cycle && (r_region == RGN_COMMIT);

    generate
        for (genvar i = 0; i < N_OUT; i++) begin : g_shadow
            opb_byte_reg #(.INIT(C_INIT)) u_shadow (
                .clk   (OPB_Clk),
                .rst_n (OPB_Rst_n),
                .we    (w_ctrl_we[i]),
                .mask  (r_mask),
                .wdata (r_wdata),
                .q     (w_ctrl_view[32*i +: 32])
            );
            opb_byte_reg #(.INIT(C_INIT)) u_user (
                .clk   (OPB_Clk),
                .rst_n (OPB_Rst_n),
                .we    (w_commit),
                .mask  (32'hFFFF_FFFF),
                .wdata (w_ctrl_view[32*i +: 32]),
                .q     (user_data_out[32*i +: 32])
            );
        end
    endgenerate

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            r_dirty  <= '0;
            r_strobe <= '0;
        end else begin
            r_strobe <= w_commit ? r_dirty : '0;
            if (w_commit)
                r_dirty <= '0;
            else
                r_dirty <= r_dirty | w_ctrl_we;
        end
    end
`else
    generate
        for (genvar i = 0; i < N_OUT; i++) begin : g_direct
            opb_byte_reg #(.INIT(C_INIT)) u_user (
                .clk   (OPB_Clk),
                .rst_n (OPB_Rst_n),
                .we    (w_ctrl_we[i]),
                .mask  (r_mask),
                .wdata (r_wdata),
                .q     (user_data_out[32*i +: 32])
            );
        end
    endgenerate

    assign w_ctrl_view = user_data_out;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n)
            r_strobe <= '0;
        else
            r_strobe <= w_ctrl_we;
    end
`endif

    assign Sl_DBus        = r_dbus;
    assign Sl_xferAck     = r_xfer_ack;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_wr_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_register_bank_ppc2simulink
// Brief    : Self-checking bench for the OPB register bank against a simple
//            word-level model of control, shadow and status registers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE  = 32'h0100_0700;
    localparam logic [31:0] HIGH  = 32'h0100_07FF;
    localparam int          N_OUT = 4;
    localparam int          N_IN  = 2;
    localparam logic [31:0] INIT  = 32'h1234_5678;
`ifdef OPB_REG_BANK_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [0:31]           OPB_ABus;
    logic [0:3]            OPB_BE;
    logic [0:31]           OPB_DBus;
    logic                  OPB_RNW;
    logic                  OPB_select;
    logic                  OPB_seqAddr;
    logic [0:31]           Sl_DBus;
    logic                  Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
    logic [32*N_OUT-1:0]   user_data_out;
    logic [N_OUT-1:0]      user_wr_strobe;
    logic [32*N_IN-1:0]    user_data_in;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .N_OUT(N_OUT), .N_IN(N_IN), .C_INIT(INIT)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_errAck(Sl_errAck),
        .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup), .Sl_xferAck(Sl_xferAck),
        .user_data_out(user_data_out), .user_wr_strobe(user_wr_strobe),
        .user_data_in(user_data_in)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: committed values, shadow values, dirty flags, status words.
    logic [31:0]      m_out [N_OUT];
    logic [31:0]      m_sh  [N_OUT];
    logic [N_OUT-1:0] m_dirty;
    logic [31:0]      stat  [N_IN];

    // Results of the most recent bus transfer.
    bit                  b_ack;
    int                  b_lat;
    logic [31:0]         b_rd;
    logic [N_OUT-1:0]    b_stb1, b_stb2, b_stb3;
    logic [32*N_OUT-1:0] b_udo1, b_udo2;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [0:3] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[31-8*b -: 8] = nw[31-8*b -: 8];
        return r;
    endfunction

    function automatic logic [32*N_OUT-1:0] model_udo();
        logic [32*N_OUT-1:0] v;
        for (int i = 0; i < N_OUT; i++) v[32*i +: 32] = m_out[i];
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int k);
        if (k < N_OUT)        return SH ? m_sh[k] : m_out[k];
        if (k < N_OUT + N_IN) return stat[k - N_OUT];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) begin m_out[i] = INIT; m_sh[i] = INIT; end
        m_dirty = '0;
    endtask

    task automatic model_write(input int k, input logic [3:0] be, input logic [31:0] d,
                               output logic [N_OUT-1:0] stb);
        stb = '0;
        if (k < N_OUT) begin
            if (SH) begin m_sh[k] = merge(m_sh[k], d, be); m_dirty[k] = 1'b1; end
            else begin m_out[k] = merge(m_out[k], d, be); stb[k] = 1'b1; end
        end else if (SH && k == N_OUT + N_IN) begin
            for (int i = 0; i < N_OUT; i++) m_out[i] = m_sh[i];
            stb = m_dirty;
            m_dirty = '0;
        end
    endtask

    task automatic drive_stat();
        for (int j = 0; j < N_IN; j++) user_data_in[32*j +: 32] = stat[j];
    endtask

    // Single transfer, started on a falling edge; waits a bounded number of cycles for ack.
    task automatic bus(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                       input logic [31:0] data);
        b_ack = 0; b_lat = -1; b_rd = '0;
        b_stb1 = '0; b_stb2 = '0; b_stb3 = '0; b_udo1 = '0; b_udo2 = '0;
        OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = data; OPB_select = 1'b1;
        for (int n = 0; n < 4 && !b_ack; n++) begin
            @(negedge clk);
            if (Sl_xferAck === 1'b1) begin
                b_ack = 1; b_lat = n; b_rd = Sl_DBus;
                b_stb1 = user_wr_strobe; b_udo1 = user_data_out;
            end
        end
        OPB_select = 1'b0; OPB_ABus = '0; OPB_RNW = 1'b0; OPB_BE = '0; OPB_DBus = '0;
        if (b_ack) begin
            @(negedge clk);
            b_stb2 = user_wr_strobe; b_udo2 = user_data_out;
            @(negedge clk);
            b_stb3 = user_wr_strobe;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin
            fails++; $display("FAIL reset_sl: ack=%b dbus=%h expected 0/0", Sl_xferAck, Sl_DBus);
        end
        checks++;
        if (user_data_out !== {N_OUT{INIT}}) begin
            fails++; $display("FAIL reset_udo: got %h expected %h", user_data_out, {N_OUT{INIT}});
        end
        checks++;
        if (user_wr_strobe !== '0) begin
            fails++; $display("FAIL reset_strobe: got %b expected 0", user_wr_strobe);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus(BASE, 1'b1, 4'hF, 32'h0);
        checks++;
        if (!b_ack || b_lat != 0) begin
            fails++; $display("FAIL reset_read_ack: ack=%0d lat=%0d expected ack at t+1", b_ack, b_lat);
        end
        checks++;
        if (b_rd !== INIT) begin
            fails++; $display("FAIL reset_read_data: got %h expected %h", b_rd, INIT);
        end
        checks++;
        if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
            fails++; $display("FAIL tied_outputs: got %b expected 000", {Sl_errAck, Sl_retry, Sl_toutSup});
        end
    endtask

    task automatic test_full_write();
        logic [N_OUT-1:0]    es;
        logic [32*N_OUT-1:0] old_udo = model_udo();
        model_write(2, 4'hF, 32'hDEAD_BEEF, es);
        bus(BASE + 32'd8, 1'b0, 4'hF, 32'hDEAD_BEEF);
        checks++;
        if (!b_ack || b_lat != 0) begin
            fails++; $display("FAIL write_ack: ack=%0d lat=%0d expected ack at t+1", b_ack, b_lat);
        end
        checks++;
        if (b_udo1 !== old_udo || b_udo2 !== model_udo()) begin
            fails++; $display("FAIL write_udo_timing: t1=%h t2=%h expected %h then %h",
                              b_udo1, b_udo2, old_udo, model_udo());
        end
        checks++;
        if (b_stb1 !== '0 || b_stb2 !== es || b_stb3 !== '0) begin
            fails++; $display("FAIL write_strobe: %b/%b/%b expected 0/%b/0", b_stb1, b_stb2, b_stb3, es);
        end
        bus(BASE + 32'd8, 1'b1, 4'hF, 32'h0);
        checks++;
        if (b_rd !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL write_readback: got %h expected deadbeef", b_rd);
        end
    endtask

    task automatic test_byte_enable();
        logic [N_OUT-1:0] es;
        model_write(1, 4'hF, 32'h0, es);
        bus(BASE + 32'd4, 1'b0, 4'hF, 32'h0);
        model_write(1, 4'b0100, 32'h1122_3344, es);
        bus(BASE + 32'd4, 1'b0, 4'b0100, 32'h1122_3344);
        checks++;
        if (b_udo2 !== model_udo() || b_stb2 !== es) begin
            fails++; $display("FAIL be_udo: got %h/%b expected %h/%b", b_udo2, b_stb2, model_udo(), es);
        end
        bus(BASE + 32'd4, 1'b1, 4'hF, 32'h0);
        checks++;
        if (b_rd !== 32'h0022_0000) begin
            fails++; $display("FAIL be_readback: got %h expected 00220000", b_rd);
        end
    endtask

    task automatic test_status();
        logic [32*N_OUT-1:0] old_udo;
        stat[0] = 32'hCAFE_F00D; stat[1] = $urandom; drive_stat();
        bus(BASE + 32'(4*N_OUT), 1'b1, 4'hF, 32'h0);
        checks++;
        if (!b_ack || b_rd !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL status_read0: ack=%0d got %h expected cafef00d", b_ack, b_rd);
        end
        bus(BASE + 32'(4*(N_OUT+1)), 1'b1, 4'hF, 32'h0);
        checks++;
        if (b_rd !== stat[1]) begin
            fails++; $display("FAIL status_read1: got %h expected %h", b_rd, stat[1]);
        end
        old_udo = model_udo();
        bus(BASE + 32'(4*N_OUT), 1'b0, 4'hF, 32'h5555_AAAA);
        checks++;
        if (!b_ack || b_stb2 !== '0 || b_udo2 !== old_udo) begin
            fails++; $display("FAIL status_write: ack=%0d stb=%b udo=%h expected 1/0/%h",
                              b_ack, b_stb2, b_udo2, old_udo);
        end
        // Status input changes just after the decode edge must not reach the read data.
        stat[0] = 32'h0BAD_CAFE; drive_stat();
        OPB_ABus = BASE + 32'(4*N_OUT); OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        @(posedge clk); #1;
        stat[0] = 32'h7777_1111; drive_stat();
        @(negedge clk);
        checks++;
        if (Sl_xferAck !== 1'b1 || Sl_DBus !== 32'h0BAD_CAFE) begin
            fails++; $display("FAIL status_capture: ack=%b got %h expected 0badcafe", Sl_xferAck, Sl_DBus);
        end
        OPB_select = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unmapped();
        bus(BASE - 32'd4, 1'b1, 4'hF, 32'h0);
        checks++;
        if (b_ack) begin
            fails++; $display("FAIL below_window: ack=%0d expected 0", b_ack);
        end
        bus(HIGH + 32'd1, 1'b0, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (b_ack) begin
            fails++; $display("FAIL above_window: ack=%0d expected 0", b_ack);
        end
        bus(BASE + 32'(4*(N_OUT+N_IN+1)), 1'b0, 4'hF, 32'hFFFF_FFFF);
        bus(BASE + 32'(4*(N_OUT+N_IN+1)), 1'b1, 4'hF, 32'h0);
        checks++;
        if (!b_ack || b_rd !== 32'h0 || user_data_out !== model_udo()) begin
            fails++; $display("FAIL unmapped_word: ack=%0d rd=%h udo=%h expected 1/0/%h",
                              b_ack, b_rd, user_data_out, model_udo());
        end
    endtask

    task automatic test_random();
        int                  k;
        logic                rnw;
        logic [3:0]          be;
        logic [31:0]         d, erd;
        logic [N_OUT-1:0]    es;
        logic [32*N_OUT-1:0] old_udo;
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, N_OUT + N_IN + 2);
            rnw = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15)); d = $urandom;
            for (int j = 0; j < N_IN; j++) stat[j] = $urandom;
            drive_stat();
            erd = rnw ? model_read(k) : 32'h0;
            old_udo = model_udo();
            es = '0;
            if (!rnw) model_write(k, be, d, es);
            bus(BASE + 32'(4*k), rnw, be, d);
            checks++;
            if (!b_ack || b_lat != 0 || b_rd !== erd) begin
                fails++; $display("FAIL rand_xfer[%0d] k=%0d rnw=%b: ack=%0d lat=%0d rd=%h expected rd=%h",
                                  n, k, rnw, b_ack, b_lat, b_rd, erd);
            end
            checks++;
            if (b_udo1 !== old_udo || b_udo2 !== model_udo()) begin
                fails++; $display("FAIL rand_udo[%0d] k=%0d: %h/%h expected %h/%h",
                                  n, k, b_udo1, b_udo2, old_udo, model_udo());
            end
            checks++;
            if (b_stb1 !== '0 || b_stb2 !== es || b_stb3 !== '0) begin
                fails++; $display("FAIL rand_strobe[%0d] k=%0d: %b/%b/%b expected 0/%b/0",
                                  n, k, b_stb1, b_stb2, b_stb3, es);
            end
        end
    endtask

`ifdef OPB_REG_BANK_SHADOW_EN
    task automatic test_shadow();
        logic [N_OUT-1:0]    es;
        logic [32*N_OUT-1:0] old_udo;
        model_write(N_OUT + N_IN, 4'hF, 32'h0, es);
        bus(BASE + 32'(4*(N_OUT+N_IN)), 1'b0, 4'hF, 32'h0);
        old_udo = model_udo();
        model_write(0, 4'hF, 32'd5, es);
        bus(BASE, 1'b0, 4'hF, 32'd5);
        model_write(3, 4'hF, 32'd7, es);
        bus(BASE + 32'd12, 1'b0, 4'hF, 32'd7);
        checks++;
        if (user_data_out !== old_udo || b_stb2 !== '0) begin
            fails++; $display("FAIL shadow_hold: udo=%h stb=%b expected %h/0", user_data_out, b_stb2, old_udo);
        end
        model_write(N_OUT + N_IN, 4'hF, 32'h0, es);
        bus(BASE + 32'(4*(N_OUT+N_IN)), 1'b0, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (b_udo1 !== old_udo || b_udo2[31:0] !== 32'd5 || b_udo2[127:96] !== 32'd7 ||
            b_udo2 !== model_udo()) begin
            fails++; $display("FAIL shadow_commit: %h/%h expected %h/%h", b_udo1, b_udo2, old_udo, model_udo());
        end
        checks++;
        if (b_stb2 !== 4'b1001 || b_stb3 !== '0) begin
            fails++; $display("FAIL shadow_strobe: got %b/%b expected 1001/0000", b_stb2, b_stb3);
        end
    endtask
`endif

    task automatic test_held_select();
        int acks = 0;
        int busy = 0;
        OPB_ABus = BASE + 32'd4; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (Sl_xferAck === 1'b1) acks++;
            else if (Sl_DBus !== 32'h0) busy++;
        end
        OPB_select = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (acks != 1 || busy != 0) begin
            fails++; $display("FAIL held_select: acks=%0d dbus_nonzero=%0d expected 1/0", acks, busy);
        end
    endtask

    task automatic test_reset_in_ack();
        OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'hA5A5_A5A5; OPB_select = 1'b1;
        @(negedge clk);
        checks++;
        if (Sl_xferAck !== 1'b1) begin
            fails++; $display("FAIL abort_setup: ack=%b expected 1", Sl_xferAck);
        end
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if (Sl_xferAck !== 1'b0 || user_data_out !== model_udo() || user_wr_strobe !== '0) begin
            fails++; $display("FAIL abort_reset: ack=%b udo=%h stb=%b expected 0/%h/0",
                              Sl_xferAck, user_data_out, user_wr_strobe, model_udo());
        end
        OPB_select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus(BASE, 1'b1, 4'hF, 32'h0);
        checks++;
        if (!b_ack || b_lat != 0 || b_rd !== INIT) begin
            fails++; $display("FAIL abort_recover: ack=%0d lat=%0d rd=%h expected 1/0/%h", b_ack, b_lat, b_rd, INIT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
        OPB_select = 1'b0; OPB_seqAddr = 1'b0;
        for (int j = 0; j < N_IN; j++) stat[j] = 32'h0;
        drive_stat();
        @(negedge clk);
        test_reset();
        test_full_write();
        test_byte_enable();
        test_status();
        test_unmapped();
        test_random();
`ifdef OPB_REG_BANK_SHADOW_EN
        test_shadow();
`endif
        test_held_select();
        test_reset_in_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised multi-register OPB slave linking the PowerPC to Simulink fabric logic. It replaces per-register single-word wrappers with one bank of N_OUT write/readback control registers plus N_IN read-only status registers, all in one address window. Each written control register raises a per-register update strobe. The block sits on the OPB beside the other chan_packet software registers. User-side logic runs on OPB_Clk; there is no second clock domain.

## Interface
- C_BASEADDR, 32'h01000700, window base (word-aligned)
- C_HIGHADDR, 32'h010007FF, window top; window must hold N_OUT+N_IN(+1) words
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
- N_OUT, 4, control registers (1..32)
- N_IN, 2, status registers (0..32)
- C_INIT, 32'h0, reset value of every control register
- OPB_Clk  in  1  sole clock
- OPB_Rst_n  in  1  reset, synchronous, active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[0] selects OPB_DBus[0:7], which maps to user bits 31:24
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored (no burst support)
- Sl_DBus  out  [0:31]  read data; zero except during read ack
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- Sl_xferAck  out  1  transfer acknowledge
- user_data_out  out  [32*N_OUT-1:0]  control regs; reg i at bits 32i+31:32i
- user_wr_strobe  out  [N_OUT-1:0]  one-cycle pulse when reg i is updated
- user_data_in  in  [32*N_IN-1:0]  status words from fabric

## Operation
- Word index k = (OPB_ABus − C_BASEADDR)>>2. k<N_OUT: control reg; N_OUT≤k<N_OUT+N_IN: status reg; k=N_OUT+N_IN: COMMIT (shadow build only); other in-window k: ack, read 0, write ignored. Out of window: no response.
- FSM: IDLE → ACK when select & hit (decode registered); ACK → WAIT unconditionally; WAIT → IDLE when select low. Sl_xferAck is 1 only in ACK.
- Write: each byte is updated only where its BE bit is 1. Writes to status regs are ignored but acked.
- Read: control reg returns its held value, or the shadow value in the shadow build. Status reg returns user_data_in sampled in the IDLE→ACK cycle. COMMIT reads 0.
- Reset: FSM IDLE; Sl_* 0; user_data_out all C_INIT; shadows C_INIT; strobes 0. A reset during ACK/WAIT aborts the transfer with no ack. The master times out.

## Timing
- Select+hit sampled at edge t; Sl_xferAck and Sl_DBus valid during cycle t+1.
- A write makes user_data_out and user_wr_strobe change at edge t+2, i.e. the cycle after the ack.
- Minimum spacing between transfers is 3 cycles. A select held high after ack never double-acks.
- A status-input change in the same cycle as decode is captured. Later changes do not alter the in-flight read.

## Configuration
- OPB_REG_BANK_SHADOW_EN defined: control writes land in shadow regs. A write of any value to COMMIT copies all shadows to user_data_out atomically at t+2. It also pulses user_wr_strobe for every reg whose shadow was written since the last commit.
- Not defined: writes go directly to user_data_out. COMMIT does not exist, and k=N_OUT+N_IN is an ordinary unmapped word.

## Structure
- Package opb_reg_bank_pkg: FSM state enum (IDLE, ACK, WAIT), k-region decode constants, and the BE→byte-mask function (OPB big-endian to little-endian user).
- One sub-module: opb_byte_reg (32-bit reg with byte-masked write and reset value), instantiated per control/shadow register.

## Test plan
- Reset then read reg 0 → ack at t+1; Sl_DBus = C_INIT; user_data_out = all C_INIT.
- Write 0xDEADBEEF to reg 2 with BE=4'b1111 → reads back 0xDEADBEEF; user_wr_strobe[2] pulses one cycle at t+2; other strobes stay 0.
- Write 0x11223344 to reg 1 with BE=4'b0100, over 0 → reg 1 = 0x00220000.
- With user_data_in[31:0]=0xCAFEF00D, read k=N_OUT → 0xCAFEF00D. Write to it → acked, no effect.
- Shadow build: write reg0=5 and reg3=7 → user_data_out unchanged. Write COMMIT → both update at the same edge; strobes[0] and [3] pulse.
- Select held for 10 cycles → exactly one ack. OPB_Rst_n low in ACK → no ack, FSM IDLE, outputs reset.
